// File: rtl/axis_packet_tracker.sv
// axis_packet_tracker
//   Per-channel packet bookkeeping for a TDEST-routed AXI-Stream FIFO. Watches
//   the ingress and egress handshakes and keeps, per channel, the number of
//   complete packets stored, whether an ingress packet is partially written,
//   a fill-threshold flag and sticky overflow/underflow flags.
//
//   Optional build macro: PKT_TRACKER_BEAT_COUNT_EN adds per-channel stored
//   beat counters and the AXIS_BEAT_COUNT output.
//
//   Ports
//     AXIS_ACLK, AXIS_ARESET          clock, async active-high reset
//     S_AXIS_TVALID/TREADY/TLAST/TDEST ingress handshake (monitor only)
//     M_AXIS_TVALID/TREADY/TLAST/TDEST egress handshake (monitor only)
//     CLEAR[n]                        sync clear of channel n
//     THRESHOLD                       shared fill level, 0 disables
//     AXIS_PACKET_COUNT               ch n at [n*W +: W]
//     PACKET_AVAILABLE/PACKET_OPEN/THRESHOLD_REACHED/OVERFLOW/UNDERFLOW per channel
//     DEST_ERROR                      sticky, handshake with out-of-range TDEST
//     AXIS_BEAT_COUNT (optional)      ch n at [n*(W+4) +: W+4]

// One channel: ingress FSM, packet counter and its flags.
module apt_chan #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_beat,    // accepted ingress beat routed here
  input  logic         in_last,
  input  logic         out_beat,   // accepted egress beat routed here
  input  logic         out_last,
  input  logic [W-1:0] thresh,
  output logic [W-1:0] cnt,
  output logic         open,
  output logic         thr_hit,
  output logic         ovf,
  output logic         udf
`ifdef PKT_TRACKER_BEAT_COUNT_EN
  ,
  output logic [W+3:0] bcnt
`endif
);
  typedef enum logic {IDLE, IN_PACKET} state_t;
  state_t st_q, st_d;

  logic         inc, dec, ovf_d, udf_d, thr_d;
  logic [W-1:0] cnt_d;
`ifdef PKT_TRACKER_BEAT_COUNT_EN
  logic [W+3:0] bcnt_d;
`endif

  assign inc = in_beat & in_last;
  assign dec = out_beat & out_last;

  always_ff @(posedge clk or posedge rst)
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;

  always_comb begin
    st_d = st_q;
    if (clr)          st_d = IDLE;
    else if (in_beat) st_d = in_last ? IDLE : IN_PACKET;
  end

  always_comb begin
    cnt_d = cnt;
    ovf_d = ovf;
    udf_d = udf;
`ifdef PKT_TRACKER_BEAT_COUNT_EN
    bcnt_d = bcnt;
`endif
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
`ifdef PKT_TRACKER_BEAT_COUNT_EN
      bcnt_d = '0;
`endif
    end else begin
      // simultaneous inc and dec cancel out, no flags
      if (inc && !dec) begin
        if (&cnt) ovf_d = 1'b1;
        else      cnt_d = cnt + 1'b1;
      end else if (dec && !inc) begin
        if (cnt == '0) udf_d = 1'b1;
        else           cnt_d = cnt - 1'b1;
      end
`ifdef PKT_TRACKER_BEAT_COUNT_EN
      if (in_beat && !out_beat) begin
        if (&bcnt) ovf_d  = 1'b1;
        else       bcnt_d = bcnt + 1'b1;
      end else if (out_beat && !in_beat) begin
        if (bcnt == '0) udf_d  = 1'b1;
        else            bcnt_d = bcnt - 1'b1;
      end
`endif
    end
    // compare against the count as it will be registered so the flag keeps
    // the same one-cycle latency as the count itself
    thr_d = (thresh != '0) && (cnt_d >= thresh);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      thr_hit <= 1'b0;
`ifdef PKT_TRACKER_BEAT_COUNT_EN
      bcnt    <= '0;
`endif
    end else begin
      cnt     <= cnt_d;
      ovf     <= ovf_d;
      udf     <= udf_d;
      thr_hit <= thr_d;
`ifdef PKT_TRACKER_BEAT_COUNT_EN
      bcnt    <= bcnt_d;
`endif
    end

  assign open = (st_q == IN_PACKET);
endmodule

module axis_packet_tracker #(
  parameter int C_NUM_CHANNELS     = 4,
  parameter int C_DEST_WIDTH       = 2,
  parameter int C_DATA_COUNT_WIDTH = 11
) (
  input  logic                                         AXIS_ACLK,
  input  logic                                         AXIS_ARESET,
  input  logic                                         S_AXIS_TVALID,
  input  logic                                         S_AXIS_TREADY,
  input  logic                                         S_AXIS_TLAST,
  input  logic [C_DEST_WIDTH-1:0]                      S_AXIS_TDEST,
  input  logic                                         M_AXIS_TVALID,
  input  logic                                         M_AXIS_TREADY,
  input  logic                                         M_AXIS_TLAST,
  input  logic [C_DEST_WIDTH-1:0]                      M_AXIS_TDEST,
  input  logic [C_NUM_CHANNELS-1:0]                    CLEAR,
  input  logic [C_DATA_COUNT_WIDTH-1:0]                THRESHOLD,
  output logic [C_NUM_CHANNELS*C_DATA_COUNT_WIDTH-1:0] AXIS_PACKET_COUNT,
  output logic [C_NUM_CHANNELS-1:0]                    PACKET_AVAILABLE,
  output logic [C_NUM_CHANNELS-1:0]                    PACKET_OPEN,
  output logic [C_NUM_CHANNELS-1:0]                    THRESHOLD_REACHED,
  output logic [C_NUM_CHANNELS-1:0]                    OVERFLOW,
  output logic [C_NUM_CHANNELS-1:0]                    UNDERFLOW,
  output logic                                         DEST_ERROR
`ifdef PKT_TRACKER_BEAT_COUNT_EN
  ,
  output logic [C_NUM_CHANNELS*(C_DATA_COUNT_WIDTH+4)-1:0] AXIS_BEAT_COUNT
`endif
);
  localparam int N = C_NUM_CHANNELS;
  localparam int W = C_DATA_COUNT_WIDTH;
  // one spare bit so the range check is never trivially constant
  localparam logic [C_DEST_WIDTH:0] NCH = C_NUM_CHANNELS[C_DEST_WIDTH:0];

  // async assert, sync release
  logic [1:0] rst_pipe;
  logic       rst_i;
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET)
    if (AXIS_ARESET) rst_pipe <= 2'b11;
    else             rst_pipe <= {rst_pipe[0], 1'b0};
  assign rst_i = rst_pipe[1];

  logic s_acc, m_acc, s_bad, m_bad;
  assign s_acc = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_acc = M_AXIS_TVALID & M_AXIS_TREADY;
  assign s_bad = s_acc && ({1'b0, S_AXIS_TDEST} >= NCH);
  assign m_bad = m_acc && ({1'b0, M_AXIS_TDEST} >= NCH);

  logic [N-1:0]        in_sel, out_sel;
  logic [N-1:0][W-1:0] cnt;
`ifdef PKT_TRACKER_BEAT_COUNT_EN
  logic [N-1:0][W+3:0] bcnt;
  assign AXIS_BEAT_COUNT = bcnt;
`endif

  for (genvar n = 0; n < N; n++) begin : g_sel
    assign in_sel[n]           = s_acc && (S_AXIS_TDEST == C_DEST_WIDTH'(n));
    assign out_sel[n]          = m_acc && (M_AXIS_TDEST == C_DEST_WIDTH'(n));
    assign PACKET_AVAILABLE[n] = |cnt[n];
  end

  apt_chan #(.W(W)) u_ch [N-1:0] (
    .clk      (AXIS_ACLK),
    .rst      (rst_i),
    .clr      (CLEAR),
    .in_beat  (in_sel),
    .in_last  (S_AXIS_TLAST),
    .out_beat (out_sel),
    .out_last (M_AXIS_TLAST),
    .thresh   (THRESHOLD),
    .cnt      (cnt),
    .open     (PACKET_OPEN),
    .thr_hit  (THRESHOLD_REACHED),
    .ovf      (OVERFLOW),
    .udf      (UNDERFLOW)
`ifdef PKT_TRACKER_BEAT_COUNT_EN
    ,
    .bcnt     (bcnt)
`endif
  );

  assign AXIS_PACKET_COUNT = cnt;

  always_ff @(posedge AXIS_ACLK or posedge rst_i)
    if (rst_i)             DEST_ERROR <= 1'b0;
    else if (&CLEAR)       DEST_ERROR <= 1'b0;
    else if (s_bad | m_bad) DEST_ERROR <= 1'b1;
endmodule
